note_sequencer: RTL
===================

# note_sequencer

Melody sequencer and sound-effect arbiter in front of `note_gen`. It walks a note ROM at a programmable tempo and drives `note_div_left`, `note_div_right` and `volume`. A one-shot sound-effect request, such as a keyboard hit, can pre-empt the melody for a bounded number of beats, after which the melody resumes exactly where it stopped. Control inputs are single-cycle pulses from `debounce`/`onepulse`.

## Interface
- `TEMPO_DIV`, 12_500_000: clk cycles per beat (8 beats/s at 100 MHz); legal ≥ 2
- `ADDR_W`, 6: ROM address width; song length ≤ 2^ADDR_W entries
- `VOL_MAX`, 5: volume ceiling; volume range is 0..VOL_MAX, 0 = mute
- `clk`  in  1  system clock; all state changes on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `play_pulse`  in  1  one-cycle pulse: start from IDLE, pause in PLAY, resume in PAUSE
- `stop_pulse`  in  1  one-cycle pulse: return to IDLE, address 0
- `vol_up` / `vol_down`  in  1 each  one-cycle volume step pulses
- `sfx_req`  in  1  level request for a sound effect
- `sfx_div`  in  22  effect divider; sampled on accept
- `sfx_beats`  in  4  effect length in beats; sampled on accept; 0 is treated as 1
- `sfx_ack`  out  1  one-cycle pulse on the cycle the effect is accepted
- `rom_addr`  out  ADDR_W  registered ROM address
- `rom_data`  in  48  asynchronous-read ROM word {beats[47:44], div_r[43:22], div_l[21:0]}; beats 0 = end-of-song
- `note_div_left` / `note_div_right`  out  22 each  registered dividers to `note_gen`; 22'd1 = silence
- `volume`  out  3  registered volume to `note_gen`
- `state`  out  3  IDLE=0, LOAD=1, PLAY=2, PAUSE=3, SFX=4

## Operation
**Reset (rst low, asynchronous):**
- state IDLE, rom_addr 0
- both divs 22'd1, volume 3, sfx_ack 0
- tick and beat counters 0; saved return state IDLE

**IDLE**
- Outputs silence.
- play_pulse → LOAD with rom_addr 0.

**LOAD** (exactly one cycle per entry)
- If rom_data.beats ≠ 0: latch div_l/div_r into outputs and beats into beat_cnt, clear tick_cnt, → PLAY.
- If beats = 0 (end-of-song) and rom_addr ≠ 0: rom_addr←0 and stay in LOAD (loop).
- If beats = 0 and rom_addr = 0 (empty song): → IDLE with silence.
- Divs hold their previous values during LOAD.

**PLAY**
- tick_cnt counts 0..TEMPO_DIV-1 and wraps.
- On each wrap, beat_cnt decrements.
- On the wrap where beat_cnt = 1: rom_addr←rom_addr+1 (wraps naturally at 2^ADDR_W), → LOAD.

**PAUSE**
- Counters and rom_addr frozen; outputs 22'd1.
- On resume, the saved note is restored from internal registers, not re-read from ROM.

**SFX**
- Accepted when sfx_req=1 in IDLE, PLAY or PAUSE. It is not accepted in LOAD; the request is deferred to the next PLAY cycle.
- On accept: sfx_ack=1 for that cycle; latch sfx_div and the effective beat count; save the current state as the return state; clear the sfx tick counter.
- Both divs = sfx_div. Melody counters and rom_addr are frozen.
- After the effective beat count × TEMPO_DIV cycles, return to the saved state with that state's outputs restored.
- sfx_req during SFX is ignored (no ack).

**Priority** (per cycle): stop_pulse > sfx_req > play_pulse.
- stop_pulse in IDLE/LOAD/PLAY/PAUSE → IDLE, rom_addr 0, silence.
- stop_pulse in SFX: the effect finishes, then returns to IDLE with rom_addr 0.

**Volume**
- vol_up increments, saturating at VOL_MAX; vol_down decrements, saturating at 0.
- Both in the same cycle: no change.
- Volume is independent of state; a stop does not reset it.

## Timing
- All outputs are registered. A control pulse at edge T is visible on outputs after edge T+1.
- **Start-up:** play_pulse at T: state=LOAD and rom_addr=0 after T+1; first note on the divs and state=PLAY after T+2.
- **Note duration:** an entry with beats=b holds PLAY for exactly b×TEMPO_DIV cycles, then 1 LOAD cycle. The note period is b×TEMPO_DIV+1.
- **End-of-song loop:** costs 2 LOAD cycles.
- **Pause/resume:** freezes tick_cnt mid-beat. Total PLAY cycles for the note are unchanged.
- **SFX:** sfx_ack and SFX state appear after the accept edge. The return state appears after exactly beats_eff×TEMPO_DIV cycles in SFX.

## Test plan
(TEMPO_DIV=4, ROM = {2,B,A},{1,D,C},{0,x,x})

1. Reset low mid-PLAY → state 0, divs 1, volume 3, rom_addr 0 immediately, without waiting for a clk edge.
2. play_pulse in IDLE → left div sequence A for 8 cycles, one LOAD cycle, C for 4 cycles, then two LOAD cycles (addr 2→0), then A again.
3. play_pulse while playing A at tick 2, hold 10 cycles, play_pulse again → divs 1 during the pause. A then continues for its remaining 5 PLAY cycles; total A PLAY cycles = 8.
4. sfx_req with sfx_div=E and sfx_beats=0 during PLAY → sfx_ack one cycle; divs E for 4 cycles; the melody resumes with the same rom_addr and the remaining ticks of the interrupted beat. A second sfx_req during SFX gets no ack.
5. stop_pulse and sfx_req asserted in the same PLAY cycle → IDLE, no ack. stop_pulse during SFX → the effect completes, then IDLE with rom_addr 0.
6. Volume: six vol_up pulses → 5 (saturates). vol_up and vol_down together → unchanged. Eight vol_down pulses → 0.

Source files
------------

// File: rtl/note_sequencer.sv
// note_sequencer: walks a note ROM at a fixed tempo, with a one-shot sound effect that can pre-empt the melody
module note_sequencer #(
  parameter int TEMPO_DIV = 12_500_000,
  parameter int ADDR_W    = 6,
  parameter int VOL_MAX   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              play_pulse,
  input  logic              stop_pulse,
  input  logic              vol_up,
  input  logic              vol_down,
  input  logic              sfx_req,
  input  logic [21:0]       sfx_div,
  input  logic [3:0]        sfx_beats,
  output logic              sfx_ack,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [47:0]       rom_data,
  output logic [21:0]       note_div_left,
  output logic [21:0]       note_div_right,
  output logic [2:0]        volume,
  output logic [2:0]        state
);
  typedef enum logic [2:0] {IDLE, LOAD, PLAY, PAUSE, SFX} state_t;
  localparam int TW = $clog2(TEMPO_DIV);
  localparam logic [TW-1:0] LAST = TW'(TEMPO_DIV - 1);
  localparam logic [21:0] SIL = 22'd1;
  state_t st, st_n, ret, ret_n;
  logic [ADDR_W-1:0] addr_n;
  logic [TW-1:0] tick, tick_n, stick, stick_n;
  logic [3:0] beat, beat_n, sbeat, sbeat_n, rom_beats;
  logic [21:0] nl, nl_n, nr, nr_n, sdiv, sdiv_n, dl_n, dr_n;
  logic [2:0] vol_n;
  logic stop_pend, stop_pend_n, tick_wrap, stick_wrap, note_end, sfx_end, accept, go_idle;
  assign rom_beats  = rom_data[47:44];
  assign tick_wrap  = tick == LAST;
  assign stick_wrap = stick == LAST;
  assign note_end   = tick_wrap && beat == 4'd1;
  assign sfx_end    = st == SFX && stick_wrap && sbeat == 4'd1;
  assign accept     = !stop_pulse && sfx_req && (st == IDLE || st == PLAY || st == PAUSE);
  assign go_idle    = (stop_pulse && st != SFX) || (sfx_end && (stop_pend || stop_pulse));
  always_comb begin
    st_n = st;
    ret_n = ret;
    addr_n = rom_addr;
    tick_n = tick;
    beat_n = beat;
    stick_n = stick;
    sbeat_n = sbeat;
    nl_n = nl;
    nr_n = nr;
    sdiv_n = sdiv;
    stop_pend_n = stop_pend;
    // melody time advances on every PLAY cycle, including the one that leaves PLAY
    if (st == PLAY) begin
      tick_n = tick_wrap ? '0 : tick + 1'b1;
      beat_n = tick_wrap ? beat - 4'd1 : beat;
      addr_n = note_end ? rom_addr + 1'b1 : rom_addr;
      st_n = note_end ? LOAD : PLAY;
      if (play_pulse) st_n = PAUSE;
    end
    if (st == LOAD && rom_beats != 4'd0) begin
      st_n = PLAY;
      nl_n = rom_data[21:0];
      nr_n = rom_data[43:22];
      beat_n = rom_beats;
      tick_n = '0;
    end else if (st == LOAD) begin
      st_n = rom_addr != '0 ? LOAD : IDLE;
      addr_n = '0;
      nl_n = rom_addr != '0 ? nl : SIL;
      nr_n = rom_addr != '0 ? nr : SIL;
    end
    if (st == PAUSE && play_pulse) st_n = beat == 4'd0 ? LOAD : PLAY;
    if (st == IDLE && play_pulse) begin
      st_n = LOAD;
      addr_n = '0;
    end
    if (st == SFX) begin
      stick_n = stick_wrap ? '0 : stick + 1'b1;
      sbeat_n = stick_wrap ? sbeat - 4'd1 : sbeat;
      stop_pend_n = stop_pend || stop_pulse;
      st_n = sfx_end ? ret : SFX;
      if (sfx_end) stop_pend_n = 1'b0;
    end
    if (accept) begin
      ret_n = (st == PLAY && note_end) ? LOAD : st;
      st_n = SFX;
      sdiv_n = sfx_div;
      sbeat_n = sfx_beats == 4'd0 ? 4'd1 : sfx_beats;
      stick_n = '0;
    end
    if (go_idle) begin
      st_n = IDLE;
      addr_n = '0;
      tick_n = '0;
      beat_n = '0;
      nl_n = SIL;
      nr_n = SIL;
    end
  end
  assign dl_n = st_n == SFX ? sdiv_n : (st_n == PLAY || st_n == LOAD) ? nl_n : SIL;
  assign dr_n = st_n == SFX ? sdiv_n : (st_n == PLAY || st_n == LOAD) ? nr_n : SIL;
  assign vol_n = (vol_up && !vol_down && volume != 3'(VOL_MAX)) ? volume + 3'd1 :
                 (vol_down && !vol_up && volume != 3'd0) ? volume - 3'd1 : volume;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st <= IDLE;
      ret <= IDLE;
      rom_addr <= '0;
      tick <= '0;
      beat <= '0;
      stick <= '0;
      sbeat <= '0;
      nl <= SIL;
      nr <= SIL;
      sdiv <= SIL;
      stop_pend <= 1'b0;
      sfx_ack <= 1'b0;
      note_div_left <= SIL;
      note_div_right <= SIL;
      volume <= 3'd3;
    end else begin
      st <= st_n;
      ret <= ret_n;
      rom_addr <= addr_n;
      tick <= tick_n;
      beat <= beat_n;
      stick <= stick_n;
      sbeat <= sbeat_n;
      nl <= nl_n;
      nr <= nr_n;
      sdiv <= sdiv_n;
      stop_pend <= stop_pend_n;
      sfx_ack <= accept;
      note_div_left <= dl_n;
      note_div_right <= dr_n;
      volume <= vol_n;
    end
  end
  assign state = st;
endmodule
